// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pipe
// Description : Two-stage pipelined bitwise logic unit with valid/ready
//               handshakes, operand chaining and zero/all-ones/parity flags.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [2:0]       op,
    input  logic             chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ones,
    output logic             parity
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_ANDN = 3'd6;

    logic             adv;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_res;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_res_q,   s1_res_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_res_q,   s2_res_d;
    logic             zero_q,     zero_d;
    logic             ones_q,     ones_d;
    logic             parity_q,   parity_d;
    logic [WIDTH-1:0] last_q,     last_d;

    // Global stall: the whole pipe moves only when the output slot can drain.
    assign adv      = !s2_valid_q || out_ready;
    assign accept   = in_valid && adv;
    assign in_ready = adv;

    // Operand select and the eight bitwise operations.
    always_comb begin
        op_a   = chain ? last_q : operand1;
        op_res = '0;
        case (op)
            OP_AND:  op_res = op_a & operand2;
            OP_OR:   op_res = op_a | operand2;
            OP_XOR:  op_res = op_a ^ operand2;
            OP_NAND: op_res = ~(op_a & operand2);
            OP_NOR:  op_res = ~(op_a | operand2);
            OP_XNOR: op_res = ~(op_a ^ operand2);
            OP_ANDN: op_res = op_a & ~operand2;
            default: op_res = ~op_a;
        endcase
    end

    // Next-state for both stages and the chain register; everything holds on stall.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_res_d   = s1_res_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        zero_d     = zero_q;
        ones_d     = ones_q;
        parity_d   = parity_q;
        last_d     = last_q;
        if (adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_res_d = op_res;
            end
            s2_valid_d = s1_valid_q;
            s2_res_d   = s1_res_q;
            zero_d     = (s1_res_q == '0);
            ones_d     = &s1_res_q;
            parity_d   = ^s1_res_q;
        end
        // Chained accepts see the value just computed, so no bubble is needed.
        if (accept) begin
            last_d = op_res;
        end
    end

    // Pipeline and chain registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_res_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            zero_q     <= 1'b1;
            ones_q     <= 1'b0;
            parity_q   <= 1'b0;
            last_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_res_q   <= s1_res_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            zero_q     <= zero_d;
            ones_q     <= ones_d;
            parity_q   <= parity_d;
            last_q     <= last_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = s2_res_q;
    assign zero      = zero_q;
    assign ones      = ones_q;
    assign parity    = parity_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_pipe
// Description : Self-checking bench for logic_unit_pipe (WIDTH=32 and WIDTH=8)
//               against a transaction-level reference model and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, chain = 1'b0, out_valid, out_ready = 1'b1;
    logic [31:0] operand1 = '0, operand2 = '0, result;
    logic [2:0]  op = '0;
    logic        zero, ones, parity;

    logic        v8 = 1'b0, rdy8, chain8 = 1'b0, ov8, or8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0, res8;
    logic [2:0]  op8 = '0;
    logic        zero8, ones8, parity8;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .operand1(operand1), .operand2(operand2), .op(op), .chain(chain),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .ones(ones), .parity(parity)
    );

    logic_unit_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
        .operand1(a8), .operand2(b8), .op(op8), .chain(chain8),
        .out_valid(ov8), .out_ready(or8), .result(res8),
        .zero(zero8), .ones(ones8), .parity(parity8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the eight operations written directly from the op table.
    function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return ~(a ^ b);
            3'd6: return a & ~b;
            default: return ~a;
        endcase
    endfunction

    typedef struct { int stamp; logic [31:0] res; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] got_log[$];
    logic [31:0] m_last   = '0;
    int          cyc      = 0;
    bit          lat_chk  = 0;
    bit          hold_chk = 0;
    logic [31:0] hold_res = '0;

    // Scoreboard for the 32-bit instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t        e;
            logic [31:0] a_eff, r;
            cyc++;
            check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (hold_chk) begin
                check("hold_valid", 64'(out_valid), 64'(1'b1));
                check("hold_result", 64'(result), 64'(hold_res));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 64'(out_valid), 64'(1'b0));
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'(result), 64'(e.res));
                    check("zero", 64'(zero), 64'(e.res == 32'h0));
                    check("ones", 64'(ones), 64'(e.res == 32'hFFFF_FFFF));
                    check("parity", 64'(parity), 64'(^e.res));
                    if (lat_chk) check("latency", 64'(cyc - e.stamp), 64'(2));
                    got_log.push_back(result);
                end
            end
            hold_chk = out_valid && !out_ready;
            hold_res = result;
            if (in_valid && in_ready) begin
                a_eff  = chain ? m_last : operand1;
                r      = ref_op(op, a_eff, operand2);
                m_last = r;
                e.stamp = cyc;
                e.res   = r;
                exp_q.push_back(e);
            end
        end
    end

    task automatic send(input logic v, input logic [2:0] o, input logic c,
                        input logic [31:0] x, input logic [31:0] y);
        @(posedge clk); #1;
        in_valid = v; op = o; chain = c; operand1 = x; operand2 = y;
    endtask

    task automatic drain();
        int k;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    logic [31:0] tbl_ops   [8] = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'hFF00_EDCB, 32'hFF0F_EDCB,
                                   32'h000F_0000, 32'h00FF_1234, 32'hF000_0000, 32'h0F0F_EDCB};
    logic [31:0] tbl_flags [3] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
    logic [31:0] tbl_chain [3] = '{32'h0000_00FF, 32'h0000_00F0, 32'hFFFF_FF0F};

    initial begin
        logic [31:0] e8;
        // Reset state and idle behaviour.
        #12;
        check("rst_out_valid", 64'(out_valid), 64'(1'b0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_zero", 64'(zero), 64'(1'b1));
        check("rst_ones", 64'(ones), 64'(1'b0));
        check("rst_parity", 64'(parity), 64'(1'b0));
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1'b1));
        repeat (5) @(negedge clk);
        check("idle_out_valid", 64'(out_valid), 64'(1'b0));

        // All eight ops back-to-back with the output always ready.
        lat_chk = 1;
        got_log.delete();
        for (int i = 0; i < 8; i++) send(1'b1, 3'(i), 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF);
        drain();
        check("allops_count", 64'(got_log.size()), 64'(8));
        for (int i = 0; i < 8; i++) check($sformatf("allops_op%0d", i), 64'(got_log[i]), 64'(tbl_ops[i]));

        // Flag corner cases.
        got_log.delete();
        send(1'b1, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'h0);
        send(1'b1, 3'd1, 1'b0, 32'h0, 32'hFFFF_FFFF);
        send(1'b1, 3'd2, 1'b0, 32'h1, 32'h0);
        drain();
        for (int i = 0; i < 3; i++) check($sformatf("flags_%0d", i), 64'(got_log[i]), 64'(tbl_flags[i]));

        // Back-to-back chaining; operand1 is junk on chained accepts.
        got_log.delete();
        send(1'b1, 3'd1, 1'b0, 32'h0, 32'h0000_00FF);
        send(1'b1, 3'd6, 1'b1, 32'hDEAD_BEEF, 32'h0000_000F);
        send(1'b1, 3'd2, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
        drain();
        for (int i = 0; i < 3; i++) check($sformatf("chain_%0d", i), 64'(got_log[i]), 64'(tbl_chain[i]));

        // Random traffic under random backpressure.
        lat_chk = 0;
        got_log.delete();
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 3) != 0);
            op        = 3'($urandom_range(0, 7));
            chain     = 1'($urandom_range(0, 1));
            operand1  = $urandom;
            operand2  = $urandom;
        end
        drain();
        check("bp_delivered_min6", 64'(got_log.size() >= 6), 64'(1'b1));

        // Reset with both stages full and the output stalled.
        out_ready = 1'b0;
        send(1'b1, 3'd0, 1'b0, 32'hAAAA_5555, 32'hFFFF_0000);
        send(1'b1, 3'd1, 1'b0, 32'h1111_0000, 32'h0000_2222);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_in_ready", 64'(in_ready), 64'(1'b0));
        check("full_out_valid", 64'(out_valid), 64'(1'b1));
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(1'b0));
        check("midrst_in_ready", 64'(in_ready), 64'(1'b1));
        exp_q.delete();
        m_last   = '0;
        hold_chk = 0;
        #1 rst = 1'b0;
        lat_chk = 1;
        out_ready = 1'b1;
        got_log.delete();
        send(1'b1, 3'd1, 1'b1, 32'hFFFF_FFFF, 32'h0000_005A);
        drain();
        check("postrst_count", 64'(got_log.size()), 64'(1));
        check("postrst_chain", 64'(got_log[0]), 64'(32'h0000_005A));

        // WIDTH=8 instance: all ops back-to-back, result two cycles after each accept.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            v8  = (i < 8);
            op8 = 3'(i);
            a8  = 8'hF4;
            b8  = 8'h3C;
            @(negedge clk);
            if (i >= 2) begin
                e8 = ref_op(3'(i - 2), 32'h0000_00F4, 32'h0000_003C) & 32'hFF;
                check("w8_valid", 64'(ov8), 64'(1'b1));
                check("w8_result", 64'(res8), 64'(e8));
                check("w8_zero", 64'(zero8), 64'(e8 == 32'h0));
                check("w8_ones", 64'(ones8), 64'(e8 == 32'hFF));
                check("w8_parity", 64'(parity8), 64'(^e8));
            end
        end
        @(negedge clk);
        check("w8_idle", 64'(ov8), 64'(1'b0));

        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined successor to the 32-bit combinational AND unit in the ALU datapath. It performs one of eight bitwise operations on two WIDTH-bit operands and produces result flags (zero, all-ones, parity). A chain mode substitutes the previous result for operand1. Transactions are accepted and delivered through valid/ready handshakes with a fixed two-cycle latency. The block sits between the register-read stage and the writeback mux.

## Interface
- WIDTH, 32: operand and result width, ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand transaction present.
- in_ready  out  1  block can accept this cycle.
- operand1  in  WIDTH  first operand; ignored when chain=1.
- operand2  in  WIDTH  second operand.
- op  in  3  operation select (see Operation).
- chain  in  1  use last accepted result in place of operand1.
- out_valid  out  1  result transaction present.
- out_ready  in  1  consumer accepts this cycle.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- ones  out  1  result == all ones.
- parity  out  1  XOR-reduction of result.

## Operation
- op encoding, where A is the effective operand1 and B is operand2: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (A & ~B), 7 NOT A (B ignored).
- Accept occurs when in_valid & in_ready.
- A = chain ? last_result : operand1.
- last_result is an internal WIDTH register, reset 0. It is loaded with the stage-1 computed value on every accept, whether or not chain is set.
- Back-to-back chained accepts see the immediately preceding result. There is no hazard bubble.
- Stage 1 (S1) registers the computed result and its valid bit.
- Stage 2 (S2) registers the result plus zero/ones/parity, which are computed from the S1 result, and drives the outputs.
- Pipeline control is a global stall: adv = !out_valid | out_ready; in_ready = adv.
- When adv = 1: S2 ← S1, and S1 ← new transaction if accepted, otherwise a bubble.
- When adv = 0: both stages hold, and no accept occurs.
- Bubbles propagate. out_valid is low for cycles carrying no transaction.
- Outputs are stable while out_valid=1 and out_ready=0. Nothing is dropped or duplicated.
- Results are delivered in acceptance order.

## Timing
- Reset, asynchronous and immediate: S1/S2 valid=0, result=0, zero=1, ones=0, parity=0, out_valid=0, last_result=0.
- After reset deassertion, in_ready=1 on the first cycle.
- Latency: accept at edge N gives out_valid=1 with the result after edge N+1, visible in cycle N+1 to N+2 when out_ready held 1. Equivalently, 2 cycles from the accept edge to the result being presented.
- Throughput is one transaction per cycle with out_ready held high.
- in_ready depends combinationally on out_valid and out_ready only. It never depends on in_valid.
- When out_ready deasserts with S1 and S2 both full, in_ready drops in the same cycle. Both transactions are retained.
- Reset asserted mid-transfer clears both stages and last_result. In-flight transactions are discarded, not delivered.
- op, chain and operands are sampled only on the accept edge. Changes while in_ready=0 have no effect.
- A chain accept directly after reset uses A=0.

## Test plan
- Reset/idle: assert rst → out_valid=0, result=0, zero=1, ones=0, parity=0, in_ready=1. Hold in_valid=0 for 5 cycles → out_valid stays 0.
- All ops, WIDTH=32, out_ready=1: operand1=0xF0F0_1234 and operand2=0x0FF0_FFFF for op 0..7 on consecutive cycles. Required results: 0x00F0_1234, 0xFFF0_FFFF, 0xFF00_EDCB, 0xFF0F_EDCB, 0x000F_0000, 0x00FF_1234, 0xF000_0000, 0x0F0F_EDCB. Each arrives 2 cycles after its accept, in order, with correct zero/ones/parity.
- Flags: AND 0xFFFF_FFFF & 0 → zero=1, parity=0. OR 0 | 0xFFFF_FFFF → ones=1, parity=0. XOR 1 ^ 0 → parity=1.
- Chain: accept OR 0 | 0x0000_00FF, then chain=1 ANDN with B=0x0000_000F, then chain=1 XOR with B=0xFFFF_FFFF back-to-back. Results must be 0x0000_00FF, 0x0000_00F0, 0xFFFF_FF0F.
- Backpressure: stream 6 transactions while toggling out_ready pseudo-randomly. Scoreboard shows no loss, no duplication and in-order delivery. result is stable whenever out_valid=1 and out_ready=0. in_ready equals !out_valid | out_ready every cycle.
- Reset mid-stream: with both stages full and out_ready=0, pulse rst for part of a cycle → out_valid=0 immediately. A following chain accept uses A=0. WIDTH=8 rerun of the all-ops scenario checks parametrisation.
